// File: rtl/aftab_mem_responder.sv
// rtl/aftab_mem_responder.sv - byte-wide backing memory for the AFTAB memRead/memWrite/memReady bus
module aftab_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] memAddr,
    input  logic [7:0]  memDataIn,
    output logic [7:0]  memDataOut,
    output logic        memReady,
    output logic        accessError
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;
    logic           lat_rd;
    logic           lat_wr;
    logic [31:0]    lat_addr;
    logic [7:0]     lat_data;
    logic           lat_fault;
    logic [7:0]     mem [DEPTH];

    logic           req;
    logic           cur_rd;
    logic           cur_wr;
    logic [31:0]    cur_addr;
    logic [7:0]     cur_data;
    logic [32:0]    cur_off;
    logic           cur_fault;
    logic [AW-1:0]  cur_idx;
    logic           enter_resp;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    end

    assign req = memRead | memWrite;

    // In IDLE the live bus is used so a zero-wait access can complete on the latching edge.
    always_comb begin
        cur_rd   = lat_rd;
        cur_wr   = lat_wr;
        cur_addr = lat_addr;
        cur_data = lat_data;
        if (state == S_IDLE) begin
            cur_rd   = memRead;
            cur_wr   = memWrite;
            cur_addr = memAddr;
            cur_data = memDataIn;
        end
        cur_off   = {1'b0, cur_addr} - {1'b0, ADDR_BASE};
        cur_fault = (cur_rd & cur_wr) | cur_off[32] | (cur_off >= 33'(DEPTH));
        cur_idx   = cur_off[AW-1:0];
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!req)                    next_state = S_IDLE;
                else if (cnt <= CW'(1))      next_state = S_RESP;
            end
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign enter_resp  = (next_state == S_RESP) && (state != S_RESP);
    assign memReady    = (state == S_RESP);
    assign accessError = (state == S_RESP) && lat_fault;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_fault  <= 1'b0;
            memDataOut <= 8'h00;
        end else begin
            if (state == S_IDLE && req) begin
                cnt       <= CW'(WAIT_CYCLES);
                lat_rd    <= memRead;
                lat_wr    <= memWrite;
                lat_addr  <= memAddr;
                lat_data  <= memDataIn;
                lat_fault <= cur_fault;
            end else if (state == S_WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (enter_resp && cur_rd)
                memDataOut <= cur_fault ? 8'h00 : mem[cur_idx];
        end
    end

    // The array has no reset; rst only suppresses a write that would land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_wr && !cur_fault)
            mem[cur_idx] <= cur_data;
    end
endmodule

// File: tb/tb_aftab_mem_responder.sv
// tb/tb_aftab_mem_responder.sv - directed vector bench for aftab_mem_responder
module tb_aftab_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  din = '0;

    logic        rd2, wr2, rd0, wr0;
    logic [7:0]  dout2, dout0, dout;
    logic        rdy2, rdy0, rdy, err2, err0, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // sel steers the shared request onto the zero-wait instance.
    assign rd2  = rd & ~sel;
    assign wr2  = wr & ~sel;
    assign rd0  = rd & sel;
    assign wr0  = wr & sel;
    assign rdy  = sel ? rdy0 : rdy2;
    assign err  = sel ? err0 : err2;
    assign dout = sel ? dout0 : dout2;

    aftab_mem_responder #(.ADDR_BASE(BASE), .DEPTH(4096), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .memRead(rd2), .memWrite(wr2), .memAddr(addr),
        .memDataIn(din), .memDataOut(dout2), .memReady(rdy2), .accessError(err2)
    );

    aftab_mem_responder #(.ADDR_BASE(BASE), .DEPTH(4096), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .memRead(rd0), .memWrite(wr0), .memAddr(addr),
        .memDataIn(din), .memDataOut(dout0), .memReady(rdy0), .accessError(err0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        exp_err;
        logic        chk_dout;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d,
                          output int n, output logic e, output logic [7:0] q, output logic pulse_ok);
        logic got;
        rd = r; wr = w; addr = a; din = d;
        n = 0; got = 1'b0; e = 1'b0; q = 8'h00;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (rdy) begin
                got = 1'b1;
                e = err;
                q = dout;
            end
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        pulse_ok = !rdy;
        if (!got) n = 99;
    endtask

    initial begin
        int          n;
        logic        e;
        logic [7:0]  q;
        logic        p;
        int          hits[2];
        int          h;
        int          k;
        logic        seen;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_1004, 8'hA5, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_1004, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_1000, 8'h5A, 1'b0, 1'b1, 8'hA5};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_2000, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0FFF, 8'h11, 1'b1, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_1000, 8'hFF, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1000, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_1FFF, 8'hC3, 1'b0, 1'b1, 8'h5A};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_1FFF, 8'h00, 1'b0, 1'b1, 8'hC3};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_2004, 8'h99, 1'b1, 1'b1, 8'hC3};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_1004, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFF, 8'h00, 1'b1, 1'b1, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_w2", rdy2, 0);
        check("reset_err_w2", err2, 0);
        check("reset_dout_w2", dout2, 8'h00);
        check("reset_ready_w0", rdy0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, n, e, q, p);
            check($sformatf("vec%0d_latency", i), n, 3);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), q, vecs[i].exp_dout);
            check($sformatf("vec%0d_pulse", i), p, 1);
        end

        sel = 1'b1;
        access(1'b0, 1'b1, 32'h0000_1010, 8'h3C, n, e, q, p);
        check("w0_write_latency", n, 1);
        check("w0_write_err", e, 0);
        access(1'b1, 1'b0, 32'h0000_1010, 8'h00, n, e, q, p);
        check("w0_read_latency", n, 1);
        check("w0_read_dout", q, 8'h3C);
        check("w0_read_pulse", p, 1);
        access(1'b1, 1'b0, 32'h0000_2000, 8'h00, n, e, q, p);
        check("w0_oow_latency", n, 1);
        check("w0_oow_err", e, 1);
        check("w0_oow_dout", q, 8'h00);
        sel = 1'b0;

        rd = 1'b1; addr = 32'h0000_1004;
        h = 0; k = 0; hits[0] = 99; hits[1] = 99;
        while (h < 2 && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (rdy) begin
                hits[h] = k;
                h++;
            end
        end
        check("b2b_dout", dout, 8'hA5);
        rd = 1'b0;
        @(posedge clk); #1;
        check("b2b_first", hits[0], 3);
        check("b2b_second", hits[1], 7);

        wr = 1'b1; addr = 32'h0000_1004; din = 8'h42;
        @(posedge clk); #1;
        wr = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy) seen = 1'b1;
        end
        check("abort_no_ready", seen, 0);
        access(1'b1, 1'b0, 32'h0000_1004, 8'h00, n, e, q, p);
        check("abort_old_byte", q, 8'hA5);

        wr = 1'b1; addr = 32'h0000_1000; din = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", rdy2, 0);
        check("rst_err", err2, 0);
        check("rst_dout", dout2, 8'h00);
        rst = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h0000_1000, 8'h00, n, e, q, p);
        check("rst_write_discarded", q, 8'h5A);
        access(1'b1, 1'b0, 32'h0000_1004, 8'h00, n, e, q, p);
        check("rst_keeps_1004", q, 8'hA5);
        sel = 1'b1;
        access(1'b1, 1'b0, 32'h0000_1010, 8'h00, n, e, q, p);
        check("rst_keeps_w0_1010", q, 8'h3C);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
